type_rule_loader: RTL and testbench
===================================

# type_rule_loader

Configuration writer for the type-lookup rule table of the 3-stage parser. Accepts a word-serial command stream from the host/control-plane over a valid/ready interface. Assembles complete type rules (valid, type data, type mask, key offsets) and commits each rule to the lookup stage with a single-cycle one-hot write enable. Sits between the control-plane register/DMA path and the rule-write port of the type-lookup stage.

## Interface
- TYPE_NUM, 4, type fields per rule
- TYPE_WIDTH, 8, bits per type field
- KEY_FILED_NUM, 8, key offset fields per rule
- KEY_OFFSET_WIDTH, 6, bits per key offset
- RULE_NUM, 4, rule entries, 1..256
- CFG_WIDTH, 32, command word width, fixed at 32

Ports:
- i_clk  in  1  single clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cfg_valid  in  1  command word valid
- i_cfg_data  in  32  command word
- o_cfg_ready  out  1  loader accepts word
- o_rule_wren  out  RULE_NUM  one-hot rule write pulse; all-ones on clear
- o_typeRule_valid  out  1  rule valid bit to write
- o_typeRule_typeData  out  TYPE_NUM×TYPE_WIDTH  type match data
- o_typeRule_typeMask  out  TYPE_NUM×TYPE_WIDTH  type match mask
- o_typeRule_keyOffset  out  KEY_FILED_NUM×KEY_OFFSET_WIDTH  key offsets
- o_cfg_done  out  1  pulse: command completed successfully
- o_cfg_err  out  1  pulse: command rejected

## Operation
- Handshake: word transferred when i_cfg_valid & o_cfg_ready. i_cfg_data is only sampled on transfer.
- Header word: [31:28] opcode, [8] rule valid, [7:0] rule index, other bits ignored.
- Opcode 1, WRITE: header, then DW data words, MW mask words, OW offset words. DW = MW = ceil(TYPE_NUM·TYPE_WIDTH/32) and OW = ceil(KEY_FILED_NUM·KEY_OFFSET_WIDTH/32). Defaults give DW=1, MW=1, OW=2, frame = 5 words.
- Payload packing: word k of a section carries bits [32k+31:32k] of the flattened field. Element 0 is in the LSBs. Bits beyond the field width are ignored.
- Opcode 2, CLEAR: header only. Drives o_rule_wren all-ones, o_typeRule_valid=0, data/mask/offset=0.
- Any other opcode: header consumed, o_cfg_err pulse, no write.
- WRITE with index ≥ RULE_NUM: full payload consumed, no wren, o_cfg_err pulse in the commit cycle.
- FSM states and transitions:
  - IDLE → DATA on WRITE.
  - IDLE → CLEAR on CLEAR.
  - IDLE → ERR on a bad opcode.
  - DATA → MASK → OFFS, each section advancing after its last word is transferred.
  - OFFS → COMMIT (→ CKSUM first when the macro is enabled).
  - COMMIT, CLEAR and ERR → IDLE after one cycle.
- Section word counter runs 0..N-1 and resets on each section change.
- Staging registers hold the assembled rule. Output rule fields update only at commit/clear and otherwise hold their last value.

## Timing
- Reset values: o_cfg_ready=0 during reset, then 1 in IDLE. o_rule_wren=0, o_typeRule_* = 0, o_cfg_done=0, o_cfg_err=0. FSM = IDLE, staging cleared.
- o_cfg_ready=1 in IDLE/DATA/MASK/OFFS/CKSUM and 0 in COMMIT/CLEAR/ERR. This gives a one-cycle bubble per command.
- Last payload word transferred in cycle N:
  - o_rule_wren, o_typeRule_*, o_cfg_done are all valid in cycle N+1.
  - wren and done are high for exactly one cycle.
  - Next header is accepted at N+2 earliest.
- CLEAR or bad-opcode header transferred in cycle N: wren/err pulse in cycle N+1.
- All outputs are registered. There is no combinational path from i_cfg_* to any output.
- i_cfg_valid low mid-frame: FSM waits indefinitely with no timeout.
- Reset mid-frame: partial frame discarded, no wren issued. The first word after reset is parsed as a header.

## Configuration
- TYPE_RULE_CKSUM_EN defined:
  - One extra trailer word follows the offset words, in state CKSUM.
  - Trailer must equal the XOR of all preceding frame words (header included).
  - On match: normal commit.
  - On mismatch: no wren, o_cfg_err pulse in the commit cycle.
  - CLEAR and bad-opcode frames carry no trailer.
- Not defined: no trailer, no CKSUM state. Frames end at the last offset word.

## Test plan
- Reset, then WRITE idx 2, valid=1: words 0x10000102, data 0x0800AA55, mask 0xFFFFFFFF, offsets 0x00000FC1, 0x0000. Expect o_rule_wren=4'b0100 for one cycle N+1, typeData[0]=0x55, typeData[3]=0x08, keyOffset[0]=1, keyOffset[1]=0x3F, done pulse.
- Back-to-back WRITEs to idx 0 and idx 3 with i_cfg_valid held high. Expect ready low exactly one cycle between frames, wren 0001 then 1000, no words lost.
- Header 0x20000000 (CLEAR). Expect wren=4'b1111, valid=0, all fields 0, done pulse next cycle.
- Header 0x10000105 (idx 5 ≥ RULE_NUM) plus 4 payload words. Expect no wren, err pulse after last word, next header parsed correctly. Header 0x70000000: err pulse, no wren.
- Assert i_rst_n low after 2 words of a WRITE. Expect all outputs 0 and no wren. A subsequent full WRITE commits normally.
- With TYPE_RULE_CKSUM_EN: correct XOR trailer → wren + done. Trailer flipped in bit 0 → no wren, err pulse.

Source files
------------

// File: rtl/type_rule_loader.sv
// rtl/type_rule_loader.sv - assembles word-serial commands into type-lookup rule writes
//
// Purpose: accepts header + payload words over a valid/ready command stream,
// stages a complete type rule, and commits it to the type-lookup stage with a
// single-cycle one-hot write enable (all-ones for CLEAR).
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cfg_valid/i_cfg_data  command word stream (32-bit words)
//   o_cfg_ready             loader accepts a word this cycle
//   o_rule_wren             one-hot rule write pulse, all-ones on CLEAR
//   o_typeRule_*            rule contents to write (valid, data, mask, offsets)
//   o_cfg_done/o_cfg_err    one-cycle command completion / rejection pulses
//
// Optional feature macro: TYPE_RULE_CKSUM_EN adds an XOR trailer word to WRITE
// frames; a trailer mismatch rejects the frame.

module type_rule_loader #(
  parameter int TYPE_NUM         = 4,
  parameter int TYPE_WIDTH       = 8,
  parameter int KEY_FILED_NUM    = 8,
  parameter int KEY_OFFSET_WIDTH = 6,
  parameter int RULE_NUM         = 4,
  parameter int CFG_WIDTH        = 32
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_cfg_valid,
  input  logic [CFG_WIDTH-1:0]                      i_cfg_data,
  output logic                                      o_cfg_ready,
  output logic [RULE_NUM-1:0]                       o_rule_wren,
  output logic                                      o_typeRule_valid,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeData,
  output logic [TYPE_NUM*TYPE_WIDTH-1:0]            o_typeRule_typeMask,
  output logic [KEY_FILED_NUM*KEY_OFFSET_WIDTH-1:0] o_typeRule_keyOffset,
  output logic                                      o_cfg_done,
  output logic                                      o_cfg_err
);

  localparam int DATA_W = TYPE_NUM * TYPE_WIDTH;
  localparam int OFFS_W = KEY_FILED_NUM * KEY_OFFSET_WIDTH;
  localparam int DW     = (DATA_W + 31) / 32;
  localparam int OW     = (OFFS_W + 31) / 32;
  localparam int MAXW   = (DW > OW) ? DW : OW;
  localparam int CNT_W  = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_CLEAR = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_MASK, S_OFFS, S_CKSUM, S_COMMIT, S_CLEAR, S_ERR
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 hdr_valid, hdr_valid_n;
  logic [7:0]           hdr_idx, hdr_idx_n;
  logic [DATA_W-1:0]    stg_data, stg_data_n;
  logic [DATA_W-1:0]    stg_mask, stg_mask_n;
  logic [OFFS_W-1:0]    stg_offs, stg_offs_n;
`ifdef TYPE_RULE_CKSUM_EN
  logic [31:0]          cksum, cksum_n;
`endif

  logic                 ready_n;
  logic [RULE_NUM-1:0]  wren_n;
  logic                 rule_valid_n;
  logic [DATA_W-1:0]    rule_data_n, rule_mask_n;
  logic [OFFS_W-1:0]    rule_offs_n;
  logic                 done_n, err_n;

  logic                 xfer;
  logic                 commit_go;
  logic                 sum_ok;
  logic                 idx_ok;

  assign xfer   = i_cfg_valid & o_cfg_ready;
  // Nine-bit compare so RULE_NUM = 256 still works.
  assign idx_ok = ({1'b0, hdr_idx} < 9'(RULE_NUM));

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hdr_valid_n  = hdr_valid;
    hdr_idx_n    = hdr_idx;
    stg_data_n   = stg_data;
    stg_mask_n   = stg_mask;
    stg_offs_n   = stg_offs;
`ifdef TYPE_RULE_CKSUM_EN
    cksum_n      = cksum;
`endif
    wren_n       = '0;
    rule_valid_n = o_typeRule_valid;
    rule_data_n  = o_typeRule_typeData;
    rule_mask_n  = o_typeRule_typeMask;
    rule_offs_n  = o_typeRule_keyOffset;
    done_n       = 1'b0;
    err_n        = 1'b0;
    commit_go    = 1'b0;
    sum_ok       = 1'b1;

    case (state)
      S_IDLE: begin
        if (xfer) begin
          hdr_valid_n = i_cfg_data[8];
          hdr_idx_n   = i_cfg_data[7:0];
          cnt_n       = '0;
`ifdef TYPE_RULE_CKSUM_EN
          cksum_n     = i_cfg_data;
`endif
          case (i_cfg_data[31:28])
            OP_WRITE: state_n = S_DATA;
            OP_CLEAR: begin
              state_n      = S_CLEAR;
              wren_n       = '1;
              rule_valid_n = 1'b0;
              rule_data_n  = '0;
              rule_mask_n  = '0;
              rule_offs_n  = '0;
              done_n       = 1'b1;
            end
            default: begin
              state_n = S_ERR;
              err_n   = 1'b1;
            end
          endcase
        end
      end

      S_DATA: begin
        if (xfer) begin
          // Word k carries flattened bits [32k+31:32k]; bits past the field are dropped.
          for (int b = 0; b < DATA_W; b++)
            if (cnt == CNT_W'(b / 32)) stg_data_n[b] = i_cfg_data[b % 32];
`ifdef TYPE_RULE_CKSUM_EN
          cksum_n = cksum ^ i_cfg_data;
`endif
          if (cnt == CNT_W'(DW - 1)) begin
            cnt_n   = '0;
            state_n = S_MASK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      S_MASK: begin
        if (xfer) begin
          for (int b = 0; b < DATA_W; b++)
            if (cnt == CNT_W'(b / 32)) stg_mask_n[b] = i_cfg_data[b % 32];
`ifdef TYPE_RULE_CKSUM_EN
          cksum_n = cksum ^ i_cfg_data;
`endif
          if (cnt == CNT_W'(DW - 1)) begin
            cnt_n   = '0;
            state_n = S_OFFS;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

      S_OFFS: begin
        if (xfer) begin
          for (int b = 0; b < OFFS_W; b++)
            if (cnt == CNT_W'(b / 32)) stg_offs_n[b] = i_cfg_data[b % 32];
`ifdef TYPE_RULE_CKSUM_EN
          cksum_n = cksum ^ i_cfg_data;
`endif
          if (cnt == CNT_W'(OW - 1)) begin
            cnt_n = '0;
`ifdef TYPE_RULE_CKSUM_EN
            state_n = S_CKSUM;
`else
            state_n   = S_COMMIT;
            commit_go = 1'b1;
`endif
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end

`ifdef TYPE_RULE_CKSUM_EN
      S_CKSUM: begin
        if (xfer) begin
          state_n   = S_COMMIT;
          commit_go = 1'b1;
          sum_ok    = (i_cfg_data == cksum);
        end
      end
`endif

      S_COMMIT, S_CLEAR, S_ERR: state_n = S_IDLE;

      default: state_n = S_IDLE;
    endcase

    // Outputs are loaded on the edge that leaves the last payload word, using
    // the *_n staging values so that word is already merged in.
    if (commit_go) begin
      if (idx_ok && sum_ok) begin
        for (int r = 0; r < RULE_NUM; r++)
          if (hdr_idx == 8'(r)) wren_n[r] = 1'b1;
        rule_valid_n = hdr_valid;
        rule_data_n  = stg_data_n;
        rule_mask_n  = stg_mask_n;
        rule_offs_n  = stg_offs_n;
        done_n       = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end

    ready_n = (state_n == S_IDLE) || (state_n == S_DATA) || (state_n == S_MASK) ||
              (state_n == S_OFFS) || (state_n == S_CKSUM);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      hdr_valid            <= 1'b0;
      hdr_idx              <= '0;
      stg_data             <= '0;
      stg_mask             <= '0;
      stg_offs             <= '0;
`ifdef TYPE_RULE_CKSUM_EN
      cksum                <= '0;
`endif
      o_cfg_ready          <= 1'b0;
      o_rule_wren          <= '0;
      o_typeRule_valid     <= 1'b0;
      o_typeRule_typeData  <= '0;
      o_typeRule_typeMask  <= '0;
      o_typeRule_keyOffset <= '0;
      o_cfg_done           <= 1'b0;
      o_cfg_err            <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      hdr_valid            <= hdr_valid_n;
      hdr_idx              <= hdr_idx_n;
      stg_data             <= stg_data_n;
      stg_mask             <= stg_mask_n;
      stg_offs             <= stg_offs_n;
`ifdef TYPE_RULE_CKSUM_EN
      cksum                <= cksum_n;
`endif
      o_cfg_ready          <= ready_n;
      o_rule_wren          <= wren_n;
      o_typeRule_valid     <= rule_valid_n;
      o_typeRule_typeData  <= rule_data_n;
      o_typeRule_typeMask  <= rule_mask_n;
      o_typeRule_keyOffset <= rule_offs_n;
      o_cfg_done           <= done_n;
      o_cfg_err            <= err_n;
    end
  end

endmodule

// File: tb/tb_type_rule_loader.sv
// tb/tb_type_rule_loader.sv - scoreboard bench for type_rule_loader

module tb_type_rule_loader;

`ifdef TYPE_RULE_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic [3:0]  rule_wren;
  logic        rule_valid;
  logic [31:0] type_data, type_mask;
  logic [47:0] key_offset;
  logic        cfg_done, cfg_err;

  always #5 clk = ~clk;

  type_rule_loader dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_cfg_valid          (cfg_valid),
    .i_cfg_data           (cfg_data),
    .o_cfg_ready          (cfg_ready),
    .o_rule_wren          (rule_wren),
    .o_typeRule_valid     (rule_valid),
    .o_typeRule_typeData  (type_data),
    .o_typeRule_typeMask  (type_mask),
    .o_typeRule_keyOffset (key_offset),
    .o_cfg_done           (cfg_done),
    .o_cfg_err            (cfg_err)
  );

  typedef struct {
    logic [3:0]  wren;
    logic        valid;
    logic [31:0] data;
    logic [31:0] mask;
    logic [47:0] offs;
    logic        done;
    logic        err;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;
  bit  pend_ready = 1'b0;

  // Reference view of the rule fields as last written.
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [31:0] m_mask  = '0;
  logic [47:0] m_offs  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per wren/done/err pulse.
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      pend_ready = 1'b0;
    end else begin
      if (pend_ready) begin
        check("ready_after_bubble", 64'(cfg_ready), 64'd1);
        pend_ready = 1'b0;
      end
      if (rule_wren != 4'd0 || cfg_done || cfg_err) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event wren=%b done=%b err=%b", rule_wren, cfg_done, cfg_err);
        end else begin
          e = sbq.pop_front();
          check("wren",  64'(rule_wren),  64'(e.wren));
          check("valid", 64'(rule_valid), 64'(e.valid));
          check("data",  64'(type_data),  64'(e.data));
          check("mask",  64'(type_mask),  64'(e.mask));
          check("offs",  64'(key_offset), 64'(e.offs));
          check("done",  64'(cfg_done),   64'(e.done));
          check("err",   64'(cfg_err),    64'(e.err));
          check("ready_bubble", 64'(cfg_ready), 64'd0);
          pend_ready = 1'b1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int gap);
    int t;
    if (gap > 0) begin
      cfg_valid = 1'b0;
      cfg_data  = $urandom;
      repeat (gap) @(negedge clk);
    end
    cfg_valid = 1'b1;
    cfg_data  = w;
    t = 0;
    while (!cfg_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      cfg_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Builds the frame for a header, records the expected outcome, then drives it.
  task automatic issue(input logic [31:0] hdr, input logic [31:0] dw, input logic [31:0] mw,
                       input logic [31:0] o0, input logic [31:0] o1,
                       input bit bad_ck, input int gapmax);
    ev_t         e;
    logic [31:0] ws[$];
    logic [31:0] x;
    bit          ok;
    ws.push_back(hdr);
    e.wren = 4'd0; e.valid = m_valid; e.data = m_data; e.mask = m_mask; e.offs = m_offs;
    e.done = 1'b0; e.err = 1'b0;
    case (hdr[31:28])
      4'd1: begin
        ws.push_back(dw); ws.push_back(mw); ws.push_back(o0); ws.push_back(o1);
        x = 32'd0;
        foreach (ws[i]) x ^= ws[i];
        if (CK_EN) ws.push_back(bad_ck ? (x ^ 32'd1) : x);
        ok = (hdr[7:0] < 8'd4) && !(CK_EN && bad_ck);
        if (ok) begin
          m_valid = hdr[8]; m_data = dw; m_mask = mw; m_offs = {o1[15:0], o0};
          e.wren = 4'(1 << hdr[7:0]);
          e.valid = m_valid; e.data = m_data; e.mask = m_mask; e.offs = m_offs;
          e.done = 1'b1;
        end else begin
          e.err = 1'b1;
        end
      end
      4'd2: begin
        m_valid = 1'b0; m_data = '0; m_mask = '0; m_offs = '0;
        e.wren = 4'hF; e.valid = 1'b0; e.data = '0; e.mask = '0; e.offs = '0;
        e.done = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    sbq.push_back(e);
    foreach (ws[i]) send_word(ws[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int          r;
    int          o;
    logic [31:0] h;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(cfg_ready),  64'd0);
    check("rst_wren",  64'(rule_wren),  64'd0);
    check("rst_valid", 64'(rule_valid), 64'd0);
    check("rst_data",  64'(type_data),  64'd0);
    check("rst_offs",  64'(key_offset), 64'd0);
    check("rst_done",  64'(cfg_done),   64'd0);
    check("rst_err",   64'(cfg_err),    64'd0);
    rst_n = 1'b1;

    // Directed WRITE idx 2; outputs are sampled in the cycle after the last word.
    issue(32'h10000102, 32'h0800AA55, 32'hFFFFFFFF, 32'h00000FC1, 32'h00000000, 1'b0, 0);
    check("dir_wren",  64'(rule_wren),         64'h4);
    check("dir_td0",   64'(type_data[7:0]),    64'h55);
    check("dir_td3",   64'(type_data[31:24]),  64'h08);
    check("dir_ko0",   64'(key_offset[5:0]),   64'h01);
    check("dir_ko1",   64'(key_offset[11:6]),  64'h3F);
    check("dir_done",  64'(cfg_done),          64'd1);

    // Back-to-back WRITEs to idx 0 and 3.
    issue(32'h10000100, 32'h11223344, 32'h0F0F0F0F, 32'h12345678, 32'h00009ABC, 1'b0, 0);
    issue(32'h10000003, 32'hDEADBEEF, 32'hFF00FF00, 32'hCAFEF00D, 32'hFFFF1234, 1'b0, 0);
    // CLEAR, out-of-range index, then a good write, then a bad opcode.
    issue(32'h20000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    issue(32'h10000105, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567, 32'h89ABCDEF, 1'b0, 0);
    issue(32'h10000101, 32'h01020304, 32'hFFFF0000, 32'h00000041, 32'h0000FFFF, 1'b0, 1);
    issue(32'h70000000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0);
    if (CK_EN) begin
      issue(32'h10000102, 32'h13579BDF, 32'h2468ACE0, 32'h0BADF00D, 32'h00001111, 1'b1, 0);
      issue(32'h10000102, 32'h13579BDF, 32'h2468ACE0, 32'h0BADF00D, 32'h00001111, 1'b0, 0);
    end

    // Reset in the middle of a WRITE: nothing may be written.
    send_word(32'h10000101, 0);
    send_word(32'h12345678, 0);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(cfg_ready),  64'd0);
    check("mid_rst_wren",  64'(rule_wren),  64'd0);
    check("mid_rst_valid", 64'(rule_valid), 64'd0);
    check("mid_rst_data",  64'(type_data),  64'd0);
    check("mid_rst_mask",  64'(type_mask),  64'd0);
    check("mid_rst_offs",  64'(key_offset), 64'd0);
    m_valid = 1'b0; m_data = '0; m_mask = '0; m_offs = '0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h10000101, 32'h77665544, 32'h00FF00FF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0);

    // Randomised mix of commands with random valid gaps.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        h = {4'h1, 19'($urandom), 1'($urandom), 8'($urandom_range(0, 3))};
      else if (r == 6)
        h = {4'h1, 19'($urandom), 1'($urandom), 8'($urandom_range(4, 255))};
      else if (r == 7)
        h = {4'h2, 28'($urandom)};
      else begin
        o = $urandom_range(0, 13);
        h = {((o == 0) ? 4'h0 : 4'(o + 2)), 28'($urandom)};
      end
      issue(h, $urandom, $urandom, $urandom, $urandom, ($urandom_range(0, 4) == 0),
            $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
